seq_signed_divider: RTL and testbench

//  Iterative signed divider; inverse of the datapath's N x N -> 2N signed array multiplier.

---
 rtl/seq_signed_divider_pkg.sv | 18 +
 rtl/seq_signed_divider_div_step.sv | 26 ++
 rtl/seq_signed_divider.sv | 121 ++++++++++++
 tb/tb_seq_signed_divider.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the iterative signed divider: state encodings,
// default operand width and the step-counter width helper.
package seq_signed_divider_pkg;

  localparam int N_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Counter must reach 2N-1 and still have headroom for the final increment.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n) + 1;
  endfunction

endpackage

// File: rtl/seq_signed_divider_div_step.sv
// One restoring-division step on magnitudes: shift the partial remainder left,
// bring in the next dividend bit, and keep the trial difference if it is non-negative.
module div_step
  import seq_signed_divider_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N:0]   rem_in,
  input  logic         dvd_bit,
  input  logic [N-1:0] dvs,
  output logic [N:0]   rem_out,
  output logic         q_bit
);

  logic [N:0]   shifted;
  logic [N+1:0] diff;

  always_comb begin
    shifted = {rem_in[N-1:0], dvd_bit};
    diff    = {1'b0, shifted} - {2'b00, dvs};
    // A bit shifted out of the top means the true value already exceeds the divisor.
    q_bit   = rem_in[N] | ~diff[N+1];
    rem_out = q_bit ? diff[N:0] : shifted;
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: 2N-bit dividend / N-bit divisor, one quotient bit per
// clock using restoring division on magnitudes, with start/busy/done handshake.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero,
  output logic           ovf
);

  localparam int             CW        = cnt_width(N);
  localparam logic [CW-1:0]  LAST_STEP = CW'(2 * N - 1);
  localparam logic [2*N-1:0] QMAX_POS  = (2*N)'((1 << (N - 1)) - 1);
  localparam logic [2*N-1:0] QMAX_NEG  = (2*N)'(1 << (N - 1));

  state_t         state_reg;
  logic [2*N-1:0] work_reg;    // dividend magnitude shifting out, quotient shifting in
  logic [N:0]     rem_reg;
  logic [N-1:0]   dvs_reg;
  logic           sign_q_reg;
  logic           sign_r_reg;
  logic           dz_reg;
  logic [CW-1:0]  count_reg;

  logic [2*N-1:0] dvd_abs;
  logic [N-1:0]   dvs_abs;
  logic [N:0]     step_rem;
  logic           step_q;
  logic [N-1:0]   q_signed;
  logic [N-1:0]   r_signed;
  logic           q_ovf;

  always_comb begin
    dvd_abs  = dividend[2*N-1] ? -dividend : dividend;
    dvs_abs  = divisor[N-1] ? -divisor : divisor;
    // Low N bits of a negation depend only on the low N bits of the operand.
    q_signed = sign_q_reg ? -work_reg[N-1:0] : work_reg[N-1:0];
    r_signed = sign_r_reg ? -rem_reg[N-1:0] : rem_reg[N-1:0];
    q_ovf    = sign_q_reg ? (work_reg > QMAX_NEG) : (work_reg > QMAX_POS);
  end

  div_step #(
    .N(N)
  ) u_step (
    .rem_in (rem_reg),
    .dvd_bit(work_reg[2*N-1]),
    .dvs    (dvs_reg),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      work_reg   <= '0;
      rem_reg    <= '0;
      dvs_reg    <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      dz_reg     <= 1'b0;
      count_reg  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      div_zero   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work_reg   <= dvd_abs;
            dvs_reg    <= dvs_abs;
            rem_reg    <= '0;
            sign_q_reg <= dividend[2*N-1] ^ divisor[N-1];
            sign_r_reg <= dividend[2*N-1];
            dz_reg     <= (divisor == '0);
            count_reg  <= '0;
            busy       <= 1'b1;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          rem_reg   <= step_rem;
          work_reg  <= {work_reg[2*N-2:0], step_q};
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST_STEP) begin
            state_reg <= FIN;
          end
        end
        FIN: begin
          // A zero divisor still runs the full iteration so latency never varies.
          quotient  <= dz_reg ? '0 : q_signed;
          remainder <= dz_reg ? '0 : r_signed;
          div_zero  <= dz_reg;
          ovf       <= ~dz_reg & q_ovf;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider (N=5): table vectors, handshake and reset
// sequences, and random operands checked through a result scoreboard.
module tb_seq_signed_divider;

  localparam int N = 5;

  typedef struct {
    int         dvd;
    int         dvs;
    logic [4:0] q;
    logic [4:0] r;
    logic       dz;
    logic       ovf;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_zero;
  logic           ovf;

  int   total;
  int   bad;
  exp_t sb[$];
  exp_t vec[13];
  bit   prev_done;

  seq_signed_divider #(
    .N(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int dvd, input int dvs);
    exp_t e;
    int   qt;
    int   rt;
    e.dvd = dvd;
    e.dvs = dvs;
    if (dvs == 0) begin
      e.q = '0; e.r = '0; e.dz = 1'b1; e.ovf = 1'b0;
    end else begin
      qt    = dvd / dvs;
      rt    = dvd % dvs;
      e.q   = qt[4:0];
      e.r   = rt[4:0];
      e.dz  = 1'b0;
      e.ovf = (qt > 15) || (qt < -16);
    end
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      total++;
      if (prev_done) begin
        bad++;
        $display("FAIL done_width: got done high 2 cycles want 1");
      end
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got q=%0d r=%0d want no done", $signed(quotient), $signed(remainder));
      end else begin
        e = sb.pop_front();
        total++;
        if ({quotient, remainder, div_zero, ovf} !== {e.q, e.r, e.dz, e.ovf}) begin
          bad++;
          $display("FAIL result %0d/%0d: got q=%0d r=%0d dz=%0b ovf=%0b want q=%0d r=%0d dz=%0b ovf=%0b",
                   e.dvd, e.dvs, $signed(quotient), $signed(remainder), div_zero, ovf,
                   $signed(e.q), $signed(e.r), e.dz, e.ovf);
        end else begin
          $display("op %0d/%0d: q=%0d r=%0d dz=%0b ovf=%0b ok", e.dvd, e.dvs,
                   $signed(quotient), $signed(remainder), div_zero, ovf);
        end
      end
    end
    prev_done = done;
  end

  // Issue one operation, scramble the operands after acceptance, and check timing.
  task automatic run_op(input exp_t e);
    int cyc;
    int busy_cyc;
    bit seen;
    dividend = e.dvd[9:0];
    divisor  = e.dvs[4:0];
    start    = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 10'($urandom);
    divisor  = 5'($urandom);
    cyc      = 1;
    busy_cyc = busy ? 1 : 0;
    seen     = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) busy_cyc++;
    end
    check("latency", seen ? cyc : -1, 12);
    check("busy_cycles", busy_cyc, 11);
  endtask

  task automatic wait_done(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    if (!seen) cyc = -1;
  endtask

  initial begin
    int   c;
    exp_t e;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    vec[0]  = '{100, 7, 5'd14, 5'd2, 1'b0, 1'b0};
    vec[1]  = '{-100, 7, 5'b10010, 5'b11110, 1'b0, 1'b0};
    vec[2]  = '{100, -7, 5'b10010, 5'd2, 1'b0, 1'b0};
    vec[3]  = '{-100, -7, 5'd14, 5'b11110, 1'b0, 1'b0};
    vec[4]  = '{240, 15, 5'b10000, 5'd0, 1'b0, 1'b1};
    vec[5]  = '{-240, 15, 5'b10000, 5'd0, 1'b0, 1'b0};
    vec[6]  = '{-512, -1, 5'd0, 5'd0, 1'b0, 1'b1};
    vec[7]  = '{7, 0, 5'd0, 5'd0, 1'b1, 1'b0};
    vec[8]  = '{9, 3, 5'd3, 5'd0, 1'b0, 1'b0};
    vec[9]  = '{511, 15, 5'd2, 5'd1, 1'b0, 1'b1};
    vec[10] = '{-1, 15, 5'd0, 5'b11111, 1'b0, 1'b0};
    vec[11] = '{-16, -16, 5'd1, 5'd0, 1'b0, 1'b0};
    vec[12] = '{0, 5, 5'd0, 5'd0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {26'd0, busy, done, quotient, remainder, div_zero, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_op(vec[i]);
    end

    // A second start while busy must be ignored entirely.
    dividend = 10'd100;
    divisor  = 5'd7;
    start    = 1'b1;
    sb.push_back(vec[0]);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dividend = 10'd50;
    divisor  = 5'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(c);
    check("repulse_done_seen", (c > 0) ? 32'd1 : 32'd0, 32'd1);
    repeat (15) @(posedge clk);
    #1;
    check("repulse_single_result", sb.size(), 0);

    // Start held through done: the second op is accepted in the done cycle.
    dividend = 10'd200;
    divisor  = 5'd9;
    start    = 1'b1;
    sb.push_back(model(200, 9));
    @(posedge clk);
    #1;
    wait_done(c);
    check("held_first_done", (c > 0) ? 32'd1 : 32'd0, 32'd1);
    dividend = 10'($signed(-150));
    divisor  = 5'd11;
    sb.push_back(model(-150, 11));
    @(posedge clk);
    #1;
    start = 1'b0;
    check("held_second_busy", {31'd0, busy}, 32'd1);
    wait_done(c);
    check("held_second_latency", c + 1, 12);

    // Reset in the middle of an operation aborts without a done pulse.
    dividend = 10'd300;
    divisor  = 5'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("midop_reset_outputs", {26'd0, busy, done, quotient, remainder, div_zero, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midop_reset_no_done", {26'd0, busy, done, quotient, remainder, div_zero, ovf}, 32'd0);

    e = model(-100, -7);
    run_op(e);

    for (int i = 0; i < 2000; i++) begin
      e = model(int'($urandom_range(1023)) - 512, int'($urandom_range(31)) - 16);
      run_op(e);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
